// File: rtl/pfu_pfmem_sched.sv
// Read-modify-write scheduler for the PFU Pauli-frame memory: arbitrates update and
// error-correction requests onto one read and one write port, with same-address forwarding.
module pfu_pfmem_sched #(
  parameter int unsigned ADDR_BW    = 6,
  parameter int unsigned DATA_BW    = 2,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               upd_valid,
  output logic               upd_ready,
  input  logic [ADDR_BW-1:0] upd_addr,
  input  logic [DATA_BW-1:0] upd_mask,
  input  logic               upd_last,
  input  logic               err_valid,
  output logic               err_ready,
  input  logic [ADDR_BW-1:0] err_addr,
  input  logic [DATA_BW-1:0] err_mask,
  input  logic               mem_stall,
  output logic               mem_rden,
  output logic [ADDR_BW-1:0] mem_raddr,
  input  logic [DATA_BW-1:0] mem_rdata,
  output logic               mem_wren,
  output logic [ADDR_BW-1:0] mem_waddr,
  output logic [DATA_BW-1:0] mem_wdata,
  output logic               upd_done,
  output logic               busy
);

  localparam int unsigned CNT_BW = $clog2(STARVE_LIM + 1);
  localparam logic [CNT_BW-1:0] LIM_C = CNT_BW'(STARVE_LIM);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    UPD   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t              state_r, state_nxt_s;
  logic [CNT_BW-1:0]   starve_cnt_r, starve_nxt_s;
  logic                gnt_upd_s, gnt_err_s, gnt_s;
  logic [ADDR_BW-1:0]  gnt_addr_s;
  logic [DATA_BW-1:0]  gnt_mask_s;
  logic                s1_valid_r, s1_src_upd_r, s1_last_r;
  logic [ADDR_BW-1:0]  s1_addr_r;
  logic [DATA_BW-1:0]  s1_mask_r;
  logic                fwd_hit_r, fwd_hit_nxt_s;
  logic [DATA_BW-1:0]  fwd_data_r;
  logic [DATA_BW-1:0]  base_s;
  logic                s1_done_s;
  logic                upd_done_r;

  // Grant arbitration: errors first unless the update stream has waited STARVE_LIM grants.
  // Grants are also held off while reset is asserted so every port idles at zero.
  always_comb begin
    gnt_upd_s = 1'b0;
    gnt_err_s = 1'b0;
    if (rst_n && !mem_stall) begin
      if (upd_valid && ((starve_cnt_r == LIM_C) || !err_valid)) begin
        gnt_upd_s = 1'b1;
      end else if (err_valid) begin
        gnt_err_s = 1'b1;
      end else begin
        gnt_upd_s = 1'b0;
        gnt_err_s = 1'b0;
      end
    end else begin
      gnt_upd_s = 1'b0;
      gnt_err_s = 1'b0;
    end
  end

  // Granted request payload and read-port drive.
  always_comb begin
    gnt_s      = gnt_upd_s | gnt_err_s;
    gnt_addr_s = {ADDR_BW{1'b0}};
    gnt_mask_s = {DATA_BW{1'b0}};
    if (gnt_upd_s) begin
      gnt_addr_s = upd_addr;
      gnt_mask_s = upd_mask;
    end else if (gnt_err_s) begin
      gnt_addr_s = err_addr;
      gnt_mask_s = err_mask;
    end else begin
      gnt_addr_s = {ADDR_BW{1'b0}};
      gnt_mask_s = {DATA_BW{1'b0}};
    end
  end

  assign upd_ready = gnt_upd_s;
  assign err_ready = gnt_err_s;
  assign mem_rden  = gnt_s;
  assign mem_raddr = gnt_addr_s;

  // Write stage: the memory returns stale data when the previous write hit the same word,
  // so the forwarded value replaces the read data in that case.
  always_comb begin
    base_s        = fwd_hit_r ? fwd_data_r : mem_rdata;
    mem_wren      = s1_valid_r;
    mem_waddr     = {ADDR_BW{1'b0}};
    mem_wdata     = {DATA_BW{1'b0}};
    if (s1_valid_r) begin
      mem_waddr = s1_addr_r;
      mem_wdata = base_s ^ s1_mask_r;
    end else begin
      mem_waddr = {ADDR_BW{1'b0}};
      mem_wdata = {DATA_BW{1'b0}};
    end
    fwd_hit_nxt_s = gnt_s & s1_valid_r & (gnt_addr_s == s1_addr_r);
    s1_done_s     = s1_valid_r & s1_src_upd_r & s1_last_r;
  end

  // Starvation counter next value.
  always_comb begin
    starve_nxt_s = starve_cnt_r;
    if (!upd_valid || gnt_upd_s) begin
      starve_nxt_s = {CNT_BW{1'b0}};
    end else if (gnt_err_s && (starve_cnt_r != LIM_C)) begin
      starve_nxt_s = starve_cnt_r + CNT_BW'(1);
    end else begin
      starve_nxt_s = starve_cnt_r;
    end
  end

  // Batch FSM next state; a new batch may start in the same cycle the previous one drains.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (gnt_upd_s) state_nxt_s = upd_last ? DRAIN : UPD;
        else           state_nxt_s = IDLE;
      end
      UPD: begin
        if (gnt_upd_s && upd_last) state_nxt_s = DRAIN;
        else                       state_nxt_s = UPD;
      end
      DRAIN: begin
        if (s1_done_s) begin
          if (gnt_upd_s) state_nxt_s = upd_last ? DRAIN : UPD;
          else           state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      starve_cnt_r <= {CNT_BW{1'b0}};
      upd_done_r   <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      starve_cnt_r <= starve_nxt_s;
      upd_done_r   <= s1_done_s;
    end
  end

  // Stage-1 request register and forwarding capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r   <= 1'b0;
      s1_addr_r    <= {ADDR_BW{1'b0}};
      s1_mask_r    <= {DATA_BW{1'b0}};
      s1_src_upd_r <= 1'b0;
      s1_last_r    <= 1'b0;
      fwd_hit_r    <= 1'b0;
      fwd_data_r   <= {DATA_BW{1'b0}};
    end else begin
      s1_valid_r <= gnt_s;
      fwd_hit_r  <= fwd_hit_nxt_s;
      fwd_data_r <= mem_wdata;
      if (gnt_s) begin
        s1_addr_r    <= gnt_addr_s;
        s1_mask_r    <= gnt_mask_s;
        s1_src_upd_r <= gnt_upd_s;
        s1_last_r    <= gnt_upd_s & upd_last;
      end
    end
  end

  assign upd_done = upd_done_r;
  assign busy     = (state_r != IDLE) | s1_valid_r;

endmodule

// File: tb/tb_pfu_pfmem_sched.sv
// Scoreboard bench for pfu_pfmem_sched: directed requests push expected writes and
// upd_done cycles into queues; a negedge monitor pops and compares as the DUT writes.
module tb_pfu_pfmem_sched;

  logic       clk;
  logic       rst_n;
  logic       upd_valid, upd_ready, upd_last;
  logic [5:0] upd_addr;
  logic [1:0] upd_mask;
  logic       err_valid, err_ready;
  logic [5:0] err_addr;
  logic [1:0] err_mask;
  logic       mem_stall, mem_rden, mem_wren, upd_done, busy;
  logic [5:0] mem_raddr, mem_waddr;
  logic [1:0] mem_rdata, mem_wdata;

  logic [1:0] fmem [0:63];
  logic       pre_we;
  logic [5:0] pre_addr;
  logic [1:0] pre_data;

  typedef struct {
    int         cyc;
    logic [5:0] addr;
    logic [1:0] data;
  } wr_t;

  wr_t wq[$];
  int  dq[$];
  wr_t got;
  int  got_cyc;
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;

  pfu_pfmem_sched dut (
    .clk(clk), .rst_n(rst_n),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_addr(upd_addr),
    .upd_mask(upd_mask), .upd_last(upd_last),
    .err_valid(err_valid), .err_ready(err_ready), .err_addr(err_addr), .err_mask(err_mask),
    .mem_stall(mem_stall), .mem_rden(mem_rden), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_wren(mem_wren), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .upd_done(upd_done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Frame memory model: registered read returning old data on read-during-write.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) fmem[i] <= 2'b00;
      mem_rdata <= 2'b00;
    end else begin
      if (mem_rden) mem_rdata <= fmem[mem_raddr];
      if (mem_wren) fmem[mem_waddr] <= mem_wdata;
      if (pre_we) fmem[pre_addr] <= pre_data;
    end
  end

  // Monitor: every write and every upd_done pulse must match the head of its queue.
  always @(negedge clk) begin
    if (rst_n && mem_wren) begin
      checks = checks + 1;
      if (wq.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_write cyc=%0d addr=%0d data=%b", cyc, mem_waddr, mem_wdata);
      end else begin
        got = wq.pop_front();
        if (got.cyc != cyc || got.addr != mem_waddr || got.data != mem_wdata) begin
          errors = errors + 1;
          $display("FAIL write actual cyc=%0d addr=%0d data=%b expected cyc=%0d addr=%0d data=%b",
                   cyc, mem_waddr, mem_wdata, got.cyc, got.addr, got.data);
        end
      end
    end
    if (rst_n && upd_done) begin
      checks = checks + 1;
      if (dq.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_upd_done cyc=%0d", cyc);
      end else begin
        got_cyc = dq.pop_front();
        if (got_cyc != cyc) begin
          errors = errors + 1;
          $display("FAIL upd_done actual cyc=%0d expected cyc=%0d", cyc, got_cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic exp_wr(input int c, input logic [5:0] a, input logic [1:0] d);
    wr_t e;
    e.cyc  = c;
    e.addr = a;
    e.data = d;
    wq.push_back(e);
  endtask

  task automatic preload(input logic [5:0] a, input logic [1:0] d);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    step();
    pre_we   = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string name);
    chk(name, 32'({upd_ready, err_ready, mem_rden, mem_wren, upd_done, busy,
                   mem_raddr, mem_waddr, mem_wdata}), 32'd0);
  endtask

  initial begin
    int b;
    rst_n = 1'b0; pre_we = 1'b0; pre_addr = 6'd0; pre_data = 2'b00;
    upd_valid = 1'b0; upd_addr = 6'd0; upd_mask = 2'b00; upd_last = 1'b0;
    err_valid = 1'b0; err_addr = 6'd0; err_mask = 2'b00; mem_stall = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("reset_outputs");
    chk("reset_state", 32'(dut.state_r), 32'd0);
    chk("reset_starve", 32'(dut.starve_cnt_r), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Single error request.
    preload(6'd5, 2'b01);
    err_valid = 1'b1; err_addr = 6'd5; err_mask = 2'b11;
    exp_wr(cyc + 1, 6'd5, 2'b10);
    @(negedge clk);
    chk("t1_err_ready", 32'(err_ready), 32'd1);
    chk("t1_upd_ready", 32'(upd_ready), 32'd0);
    chk("t1_rden", 32'(mem_rden), 32'd1);
    chk("t1_raddr", 32'(mem_raddr), 32'd5);
    step();
    err_valid = 1'b0;
    @(negedge clk);
    chk("t1_busy_write", 32'(busy), 32'd1);
    step();
    @(negedge clk);
    chk("t1_busy_after", 32'(busy), 32'd0);

    // Equal addresses: error first, update follows with forwarded base.
    step();
    err_valid = 1'b1; err_addr = 6'd3; err_mask = 2'b01;
    upd_valid = 1'b1; upd_addr = 6'd3; upd_mask = 2'b10; upd_last = 1'b1;
    exp_wr(cyc + 1, 6'd3, 2'b01);
    exp_wr(cyc + 2, 6'd3, 2'b11);
    dq.push_back(cyc + 3);
    @(negedge clk);
    chk("t2_err_first", 32'({err_ready, upd_ready}), 32'd2);
    step();
    err_valid = 1'b0;
    @(negedge clk);
    chk("t2_upd_second", 32'({err_ready, upd_ready}), 32'd1);
    step();
    upd_valid = 1'b0; upd_last = 1'b0;
    @(negedge clk);
    chk("t2_state_drain", 32'(dut.state_r), 32'd2);
    step();
    @(negedge clk);
    chk("t2_state_idle", 32'(dut.state_r), 32'd0);
    chk("t2_busy", 32'(busy), 32'd0);

    // Starvation: four error grants, then one update grant, then errors again.
    step();
    b = cyc;
    err_valid = 1'b1; err_addr = 6'd10; err_mask = 2'b01;
    upd_valid = 1'b1; upd_addr = 6'd20; upd_mask = 2'b10; upd_last = 1'b1;
    exp_wr(b + 1, 6'd10, 2'b01);
    exp_wr(b + 2, 6'd10, 2'b00);
    exp_wr(b + 3, 6'd10, 2'b01);
    exp_wr(b + 4, 6'd10, 2'b00);
    exp_wr(b + 5, 6'd20, 2'b10);
    exp_wr(b + 6, 6'd10, 2'b01);
    dq.push_back(b + 6);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("t3_grant_%0d", i), 32'({err_ready, upd_ready}),
          (i == 4) ? 32'd1 : 32'd2);
      step();
    end
    err_valid = 1'b0; upd_valid = 1'b0; upd_last = 1'b0;
    step();
    @(negedge clk);
    chk("t3_busy", 32'(busy), 32'd0);

    // Update batch of three, last one flagged.
    step();
    b = cyc;
    for (int i = 0; i < 3; i++) begin
      upd_valid = 1'b1;
      upd_addr  = 6'(30 + i);
      upd_mask  = 2'(i + 1);
      upd_last  = (i == 2);
      exp_wr(b + i + 1, 6'(30 + i), 2'(i + 1));
      @(negedge clk);
      chk($sformatf("t4_upd_ready_%0d", i), 32'(upd_ready), 32'd1);
      if (i == 1) chk("t4_state_upd", 32'(dut.state_r), 32'd1);
      step();
    end
    dq.push_back(b + 4);
    upd_valid = 1'b0; upd_last = 1'b0;
    @(negedge clk);
    chk("t4_state_drain", 32'(dut.state_r), 32'd2);
    step();
    @(negedge clk);
    chk("t4_state_idle", 32'(dut.state_r), 32'd0);
    chk("t4_busy", 32'(busy), 32'd0);

    // Stall the cycle after a grant: pending write completes, no new grant until it drops.
    step();
    err_valid = 1'b1; err_addr = 6'd40; err_mask = 2'b11;
    exp_wr(cyc + 1, 6'd40, 2'b11);
    @(negedge clk);
    chk("t5_grant", 32'(err_ready), 32'd1);
    step();
    mem_stall = 1'b1; err_addr = 6'd41; err_mask = 2'b01;
    @(negedge clk);
    chk("t5_stall_ready", 32'({err_ready, upd_ready, mem_rden}), 32'd0);
    chk("t5_stall_wren", 32'(mem_wren), 32'd1);
    step();
    mem_stall = 1'b0;
    exp_wr(cyc + 1, 6'd41, 2'b01);
    @(negedge clk);
    chk("t5_regrant", 32'(err_ready), 32'd1);
    step();
    err_valid = 1'b0;
    step();

    // Reset the cycle after a grant: pending write discarded.
    err_valid = 1'b1; err_addr = 6'd50; err_mask = 2'b11;
    upd_valid = 1'b1; upd_addr = 6'd51; upd_mask = 2'b01; upd_last = 1'b0;
    @(negedge clk);
    chk("t6_grant", 32'(err_ready), 32'd1);
    step();
    rst_n = 1'b0; err_valid = 1'b0; upd_valid = 1'b0;
    #1;
    chk_idle_outputs("t6_reset_outputs");
    chk("t6_state", 32'(dut.state_r), 32'd0);
    chk("t6_starve", 32'(dut.starve_cnt_r), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    @(negedge clk);
    chk("t6_no_write", 32'({mem_wren, busy}), 32'd0);
    step();
    step();

    chk("write_queue_empty", 32'(wq.size()), 32'd0);
    chk("done_queue_empty", 32'(dq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
